// File: rtl/tdm_demux16.sv
// Receive side of the TDM serial link: aligns a slot counter to the frame-sync
// marker, scatters each strobed bit into its slot and publishes whole frames.
module tdm_demux16 #(
    parameter int SEL_W       = 4,
    parameter bit STRICT_SYNC = 1'b1,
    localparam int SLOTS      = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             din,
    output logic [SLOTS-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SLOT_ZERO = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SLOT_LAST = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] SLOT_ONE  = SLOT_ZERO + {{(SEL_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SEL_W-1:0]   slot_r;
    logic [SEL_W-1:0]   slot_nxt_s;
    logic [SLOTS-1:0]   asm_r;
    logic [SLOTS-1:0]   asm_nxt_s;
    logic [SLOTS-1:0]   out_r;
    logic [SLOTS-1:0]   out_nxt_s;
    logic               valid_r;
    logic               valid_nxt_s;
    logic               err_r;
    logic               err_nxt_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: lock on a qualified sync, drop lock on a missing one in strict mode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HUNT: begin
                if (en && sync) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (en && !sync && (slot_r == SLOT_ZERO) && (STRICT_SYNC == 1'b1)) begin
                    state_nxt_s = ST_HUNT;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
            end
        endcase
    end

    // Datapath next values: slot tracking, bit scatter, frame publication and error pulse
    always_comb begin
        slot_nxt_s  = slot_r;
        asm_nxt_s   = asm_r;
        out_nxt_s   = out_r;
        valid_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        if (en) begin
            case (state_r)
                ST_HUNT: begin
                    if (sync) begin
                        asm_nxt_s[0] = din;
                        slot_nxt_s   = SLOT_ONE;
                    end else begin
                        slot_nxt_s   = SLOT_ZERO;
                    end
                end
                ST_LOCKED: begin
                    if (sync) begin
                        // A sync anywhere but slot 0 abandons the partial frame and realigns
                        err_nxt_s    = (slot_r != SLOT_ZERO);
                        asm_nxt_s[0] = din;
                        slot_nxt_s   = SLOT_ONE;
                    end else if ((slot_r == SLOT_ZERO) && (STRICT_SYNC == 1'b1)) begin
                        err_nxt_s    = 1'b1;
                        slot_nxt_s   = SLOT_ZERO;
                    end else begin
                        asm_nxt_s[slot_r] = din;
                        slot_nxt_s        = slot_r + SLOT_ONE;
                        if (slot_r == SLOT_LAST) begin
                            out_nxt_s   = asm_nxt_s;
                            valid_nxt_s = 1'b1;
                        end else begin
                            out_nxt_s   = out_r;
                            valid_nxt_s = 1'b0;
                        end
                    end
                end
                default: begin
                    slot_nxt_s = SLOT_ZERO;
                end
            endcase
        end else begin
            slot_nxt_s = slot_r;
        end
    end

    // Datapath registers; everything clears immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r  <= SLOT_ZERO;
            asm_r   <= {SLOTS{1'b0}};
            out_r   <= {SLOTS{1'b0}};
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            slot_r  <= slot_nxt_s;
            asm_r   <= asm_nxt_s;
            out_r   <= out_nxt_s;
            valid_r <= valid_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign out       = out_r;
    assign out_valid = valid_r;
    assign slot      = slot_r;
    assign locked    = (state_r == ST_LOCKED);
    assign sync_err  = err_r;

endmodule
